// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam int          INSTR_W    = 32;
  localparam logic [5:0]  OP_J       = 6'b000010;
  localparam logic [5:0]  OP_BEQ     = 6'b000100;
  localparam int          WORD_BYTES = 4;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_dest(input logic [31:0] pc4, input logic [25:0] target);
    return {pc4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the instruction currently held at decode.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] instr_pc_i,
  input  logic [25:0] instr_fields_i,
  input  logic        take_branch_i,
  input  logic        take_jump_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc4;

  always_comb begin
    pc4       = instr_pc_i + 32'(WORD_BYTES);
    next_pc_o = pc4;
    // Jump outranks branch when decode asserts both.
    if (take_jump_i) begin
      next_pc_o = jump_dest(pc4, instr_fields_i);
    end else if (take_branch_i) begin
      next_pc_o = pc4 + branch_offset(instr_fields_i[15:0]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, variable-latency imem request, valid/ready hand-off to decode.
//   state | meaning
//   FETCH | request outstanding at pc, waiting for imem_ack
//   HOLD  | instruction presented to decode, waiting for instr_ready
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [31:0]          instr_pc,
  input  logic                 take_branch,
  input  logic                 take_jump,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e          state_q;
  logic                  req_q;
  logic                  valid_q;
  logic [31:0]           pc_q;
  logic [INSTR_W-1:0]    instr_q;
  logic [31:0]           instr_pc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [31:0]           next_pc_d;

  next_pc_calc u_next_pc (
    .instr_pc_i     (instr_pc_q),
    .instr_fields_i (instr_q[25:0]),
    .take_branch_i  (take_branch),
    .take_jump_i    (take_jump),
    .next_pc_o      (next_pc_d)
  );

  // req_q stays low through reset and rises on the first edge after release,
  // so an ack is only honoured once the request is actually visible.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC_ALIGNED;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && imem_ack) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= HOLD;
          end else begin
            req_q <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_q    <= next_pc_d;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model pushes acked words, decode side pops and checks.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        take_branch;
  logic        take_jump;
  logic [31:0] retired_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } txn_t;

  txn_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_addr;
  logic [31:0] exp_cnt;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .take_branch (take_branch),
    .take_jump   (take_jump),
    .retired_cnt (retired_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic br, input logic jp);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(w[15:0]));
    if (jp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br) return p4 + 32'(off * 4);
    return p4;
  endfunction

  function automatic logic [31:0] beq_w(input logic [15:0] imm);
    return {6'b000100, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] j_w(input logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  // Memory side: wait for request, hold off lat cycles, then ack with word.
  task automatic fetch(input int lat, input logic [31:0] word);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (imem_req !== 1'b1) begin
      check_eq("req_timeout", {31'b0, imem_req}, 32'd1);
      return;
    end
    for (int i = 0; i < lat; i++) begin
      check_eq("addr_wait", imem_addr, exp_addr);
      check_eq("valid_wait", {31'b0, instr_valid}, 32'd0);
      check_eq("req_wait", {31'b0, imem_req}, 32'd1);
      @(negedge CLK);
    end
    check_eq("addr_ack", imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb.push_back('{pc: exp_addr, word: word});
    @(negedge CLK);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_eq("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check_eq("req_after_ack", {31'b0, imem_req}, 32'd0);
  endtask

  // Decode side: optional stall with take_branch toggling, then handshake.
  task automatic consume(input int stall, input logic br, input logic jp);
    txn_t t;
    if (sb.size() == 0) begin
      check_eq("sb_empty", {31'b0, instr_valid}, 32'd0);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      take_branch = i[0];
      @(negedge CLK);
      check_eq("stall_instr", instr, sb[0].word);
      check_eq("stall_pc", instr_pc, sb[0].pc);
      check_eq("stall_req", {31'b0, imem_req}, 32'd0);
      check_eq("stall_addr", imem_addr, exp_addr);
    end
    t = sb.pop_front();
    check_eq("valid_hs", {31'b0, instr_valid}, 32'd1);
    check_eq("instr", instr, t.word);
    check_eq("instr_pc", instr_pc, t.pc);
    take_branch = br;
    take_jump   = jp;
    instr_ready = 1'b1;
    exp_addr    = model_next(t.pc, t.word, br, jp);
    exp_cnt     = exp_cnt + 32'd1;
    @(negedge CLK);
    instr_ready = 1'b0;
    take_branch = 1'b0;
    take_jump   = 1'b0;
    check_eq("valid_after_hs", {31'b0, instr_valid}, 32'd0);
    check_eq("req_after_hs", {31'b0, imem_req}, 32'd1);
    check_eq("next_addr", imem_addr, exp_addr);
    check_eq("retired_cnt", retired_cnt, exp_cnt);
  endtask

  initial begin
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    take_branch = 1'b0;
    take_jump   = 1'b0;
    exp_addr    = 32'h0;
    exp_cnt     = 32'h0;
    repeat (2) @(negedge CLK);
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_cnt", retired_cnt, 32'h0);
    reset_n = 1'b1;

    // Zero-wait sequential fetches 0,4,8,C, then a 3-cycle wait at 0x10.
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'h2000_0000 | 32'(i));
      consume(0, 1'b0, 1'b0);
    end
    fetch(3, 32'h2000_0010);
    consume(0, 1'b0, 1'b0);

    // 0x14..0x1C sequential, backward branch at 0x20, then forward branch at 0x20.
    for (int i = 0; i < 3; i++) begin
      fetch(1, 32'h2000_0100);
      consume(0, 1'b0, 1'b0);
    end
    fetch(0, beq_w(16'hFFFE));
    consume(0, 1'b1, 1'b0);
    fetch(2, 32'h2000_0200);
    consume(0, 1'b0, 1'b0);
    fetch(0, beq_w(16'h0003));
    consume(0, 1'b1, 1'b0);

    // Jumps carry pc4[31:28] across region boundaries up to 0x3FFF_FFFC.
    for (int i = 0; i < 4; i++) begin
      fetch(i % 2, j_w(26'h3FF_FFFF));
      consume(0, 1'b0, 1'b1);
    end
    fetch(0, beq_w(16'h0004));
    consume(0, 1'b1, 1'b0);

    // Jump wins over branch at 0x4000_0010.
    fetch(0, j_w(26'h000_0040));
    consume(0, 1'b1, 1'b1);

    // Long stall in HOLD, released with no branch.
    fetch(1, beq_w(16'h0010));
    consume(5, 1'b0, 1'b0);

    // Reset mid-wait, then branch to top of memory and wrap.
    for (int i = 0; i < 2; i++) begin
      check_eq("pre_rst_addr", imem_addr, exp_addr);
      @(negedge CLK);
    end
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_req", {31'b0, imem_req}, 32'd0);
    check_eq("async_addr", imem_addr, 32'h0);
    check_eq("async_cnt", retired_cnt, 32'h0);
    check_eq("async_pc", instr_pc, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("rst_hold_req", {31'b0, imem_req}, 32'd0);
    sb.delete();
    exp_addr = 32'h0;
    exp_cnt  = 32'h0;
    reset_n  = 1'b1;
    fetch(0, beq_w(16'hFFFE));
    consume(0, 1'b1, 1'b0);
    fetch(0, 32'h2000_0300);
    consume(0, 1'b0, 1'b0);
    fetch(0, 32'h2000_0400);
    consume(0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
